asm_mem_loader: RTL
===================

Name: asm_mem_loader

Overview:
Downstream consumer of the assembled-program AXI-Stream produced by the byte/ASCII parser.
- Beats with tuser=1 are channel_update commands that set the write cursor and mode.
- Beats with tuser=0 are 128-bit data chunks, turned into sequential memory write requests on a registered valid/ready write port.
- Sits between the parser and the memory/channel arbiter, and loads program images into DRAM/BRAM at boot.

Parameters:
ADDR_W, 27, width of the word address (32-bit-word units); matches channel_update.addr.
DATA_W, 128, width of data beats and memory writes.
WORDS_PER_BEAT, 4, address increment per data beat (DATA_W/32).

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
s_axis_tuser  input  1  1 = beat is a channel_update command, 0 = data chunk
s_axis_data  input  128  beat payload
s_axis_valid  input  1  upstream beat valid
s_axis_ready  output  1  block accepts beat this cycle
mem_addr  output  ADDR_W  word address of the write
mem_data  output  DATA_W  write data
mem_valid  output  1  write request valid
mem_ready  input  1  memory accepts request
loading  output  1  state is LOAD
beats_written  output  32  count of accepted memory writes since reset
err_orphan  output  1  sticky: a data beat arrived in IDLE and was dropped

Behaviour:
- One clock; reset is synchronous and active-high (clk_in, rst_in).
- Reset values: mem_valid=0, mem_addr=0, mem_data=0, loading=0, beats_written=0, err_orphan=0, state=IDLE, cursor=0, remaining=0.
- Command decode of s_axis_data (packed channel_update, MSB first):
  - addr = [54:28]
  - stream_length = [27:1]
  - wen = [0]
  - Bits [127:55] are ignored.
- Handshake:
  - Beat transfers when s_axis_valid && s_axis_ready.
  - s_axis_ready = !mem_valid || mem_ready, so there is a single registered output stage.
  - Command beats and dropped beats are always accepted when s_axis_ready=1.
  - Output regs hold stable while mem_valid && !mem_ready; the port complies with AXI stability rules.
  - mem_valid clears on mem_ready unless a new write loads in the same cycle.
- Latency: data beat accepted in cycle N -> mem_valid=1 with its data in cycle N+1.
- State machine: IDLE, LOAD, DROP.
- Any command beat, in any state:
  - cursor <= addr; remaining <= stream_length; unbounded <= (stream_length==0).
  - Next state = wen ? LOAD : DROP.
- Data beat in LOAD:
  - mem_addr <= cursor; mem_data <= beat; mem_valid <= 1.
  - cursor <= cursor + WORDS_PER_BEAT, modulo 2^ADDR_W (wraps silently).
  - If !unbounded: remaining <= remaining-1; when it reaches 0 (this was the last beat), state <= IDLE.
- Data beat in DROP: discarded. No write is issued, cursor is unchanged, and the remaining countdown still applies; reaching 0 returns to IDLE.
- Data beat in IDLE: discarded and err_orphan <= 1. err_orphan clears only on reset.
- beats_written increments on each mem_valid && mem_ready and wraps at 2^32.
- loading = (state==LOAD).
- A command arriving while the previous write is stalled waits for s_axis_ready. The stalled write completes with the old address; the command is never merged into it.
- Reset mid-stream: any pending write is abandoned (mem_valid=0 next cycle), and all state and counters return to reset values.

Decomposition:
- Package fpga_proc_pkg:
  - channel_update typedef (addr, stream_length, wen; 27/27/1 bits).
  - Constants CU_ADDR_LSB=28, CU_LEN_LSB=1.
  - loader_state enum.
- The parser uses the same package, which replaces its ifndef guard.
- Optional sub-module axis_reg_slice (single-entry registered valid/ready stage) for the mem_* port; the FSM/cursor logic stays in asm_mem_loader.

Test Plan:
1. Command addr=0x100, len=0, wen=1, then 3 data beats D0..D2 with mem_ready=1 -> writes (0x100,D0), (0x104,D1), (0x108,D2), one cycle after each accept; beats_written=3; loading stays 1.
2. Command addr=0x200, len=2, then 3 data beats -> writes at 0x200 and 0x204 only; third beat dropped with err_orphan=1; loading=0 after second beat.
3. Backpressure: mem_ready held 0 for 5 cycles during the test-1 stream -> s_axis_ready=0 while mem_valid=1; mem_addr/mem_data stable; no beat lost or duplicated after release.
4. Command wen=0, len=2, then 2 beats, then command wen=1 addr=0x10 and 1 beat -> no writes for the first two beats; one write at 0x10.
5. Cursor wrap: addr=0x7FFFFFC, 2 beats -> writes at 0x7FFFFFC then 0x0000000.
6. Assert rst_in while mem_valid=1 mid-stream -> next cycle mem_valid=0, beats_written=0, state IDLE; a following data beat sets err_orphan.

Source files
------------

// File: rtl/fpga_proc_pkg.sv
// Shared types and constants for the assembled-program path (parser -> loader).
// Ports: none (package).
package fpga_proc_pkg;

  localparam int unsigned ADDR_W         = 27;
  localparam int unsigned DATA_W         = 128;
  localparam int unsigned WORDS_PER_BEAT = 4;
  localparam int unsigned LEN_W          = 27;

  // Bit positions of the channel_update fields inside a command beat
  localparam int unsigned CU_ADDR_LSB = 28;
  localparam int unsigned CU_LEN_LSB  = 1;

  // Command payload, MSB first: addr[54:28], stream_length[27:1], wen[0]
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  stream_length;
    logic              wen;
  } channel_update_t;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_LOAD = 2'd1,
    LS_DROP = 2'd2
  } loader_state_e;

  // Memory write request payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/asm_mem_loader_if.sv
// Bus bundle for the loader: upstream AXI-Stream beats in, memory write requests out.
// Ports: s_axis_{tuser,data,valid,ready}, mem_{addr,data,valid,ready}.
//   slave  - the loader's view (consumes beats, produces writes)
//   master - the environment's view (produces beats, consumes writes)
interface asm_mem_loader_if;
  import fpga_proc_pkg::*;

  logic              s_axis_tuser;
  logic [DATA_W-1:0] s_axis_data;
  logic              s_axis_valid;
  logic              s_axis_ready;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;
  logic              mem_ready;

  modport slave (
    input  s_axis_tuser, s_axis_data, s_axis_valid,
    output s_axis_ready,
    output mem_addr, mem_data, mem_valid,
    input  mem_ready
  );

  modport master (
    output s_axis_tuser, s_axis_data, s_axis_valid,
    input  s_axis_ready,
    input  mem_addr, mem_data, mem_valid,
    output mem_ready
  );

endinterface

// File: rtl/asm_mem_loader_reg_slice.sv
// Single-entry registered valid/ready stage for memory write requests.
// Ports: clk_in/rst_in; in_valid/in_ready_c/in_req (load side);
//        out_valid/out_ready/out_req (registered memory side).
module asm_mem_loader_reg_slice
  import fpga_proc_pkg::*;
(
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     in_valid,
  output logic     in_ready_c,
  input  mem_req_t in_req,
  output logic     out_valid,
  input  logic     out_ready,
  output mem_req_t out_req
);

  logic     valid_q, valid_d;
  mem_req_t req_q, req_d;

  // Room for a new entry when empty or the current one drains this cycle
  assign in_ready_c = !valid_q || out_ready;

  // Next-entry logic: a new load takes priority over the drain
  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (in_valid && in_ready_c) begin
      valid_d = 1'b1;
      req_d   = in_req;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign out_valid = valid_q;
  assign out_req   = req_q;

endmodule

// File: rtl/asm_mem_loader.sv
// Consumes the assembled-program stream: command beats (tuser=1) set the write
// cursor/mode, data beats (tuser=0) become sequential memory writes.
// Ports: clk_in, rst_in (sync, active-high); bus (slave modport: s_axis_* in,
//        mem_* out); loading (state is LOAD); beats_written (accepted writes);
//        err_orphan (sticky: data beat seen while IDLE).
module asm_mem_loader
  import fpga_proc_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  asm_mem_loader_if.slave         bus,
  output logic                    loading,
  output logic [31:0]             beats_written,
  output logic                    err_orphan
);

  localparam logic [1:0] ST_IDLE = LS_IDLE;
  localparam logic [1:0] ST_LOAD = LS_LOAD;
  localparam logic [1:0] ST_DROP = LS_DROP;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              unbounded_q, unbounded_d;
  logic              err_orphan_q, err_orphan_d;
  logic              loading_q, loading_d;
  logic [31:0]       beats_written_q, beats_written_d;

  logic              s_ready_c;
  logic              wr_load_c;
  logic              accept_c;
  channel_update_t   cu_c;
  mem_req_t          wr_req_c;
  mem_req_t          out_req;

  assign accept_c = bus.s_axis_valid && s_ready_c;

  // Command field extraction; upper bits of the beat are don't-care
  assign cu_c.addr          = bus.s_axis_data[CU_ADDR_LSB +: ADDR_W];
  assign cu_c.stream_length = bus.s_axis_data[CU_LEN_LSB +: LEN_W];
  assign cu_c.wen           = bus.s_axis_data[0];

  assign wr_req_c.addr = cursor_q;
  assign wr_req_c.data = bus.s_axis_data;

  // Next-state, cursor and countdown logic
  always_comb begin
    state_d         = state_q;
    cursor_d        = cursor_q;
    remaining_d     = remaining_q;
    unbounded_d     = unbounded_q;
    err_orphan_d    = err_orphan_q;
    beats_written_d = beats_written_q;
    wr_load_c       = 1'b0;

    if (accept_c && bus.s_axis_tuser) begin
      cursor_d    = cu_c.addr;
      remaining_d = cu_c.stream_length;
      unbounded_d = (cu_c.stream_length == '0);
      state_d     = cu_c.wen ? ST_LOAD : ST_DROP;
    end else if (accept_c) begin
      case (state_q)
        ST_LOAD, ST_DROP: begin
          if (state_q == ST_LOAD) begin
            wr_load_c = 1'b1;
            cursor_d  = cursor_q + ADDR_W'(WORDS_PER_BEAT);
          end
          // remaining==1 means this beat is the last of a bounded stream
          if (!unbounded_q) begin
            remaining_d = remaining_q - LEN_W'(1);
            if (remaining_q == LEN_W'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: err_orphan_d = 1'b1;
      endcase
    end

    if (bus.mem_valid && bus.mem_ready) begin
      beats_written_d = beats_written_q + 32'd1;
    end

    loading_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= ST_IDLE;
      cursor_q        <= '0;
      remaining_q     <= '0;
      unbounded_q     <= 1'b0;
      err_orphan_q    <= 1'b0;
      loading_q       <= 1'b0;
      beats_written_q <= '0;
    end else begin
      state_q         <= state_d;
      cursor_q        <= cursor_d;
      remaining_q     <= remaining_d;
      unbounded_q     <= unbounded_d;
      err_orphan_q    <= err_orphan_d;
      loading_q       <= loading_d;
      beats_written_q <= beats_written_d;
    end
  end

  // Registered output stage; its free slot also gates upstream acceptance
  asm_mem_loader_reg_slice u_slice (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .in_valid   (wr_load_c),
    .in_ready_c (s_ready_c),
    .in_req     (wr_req_c),
    .out_valid  (bus.mem_valid),
    .out_ready  (bus.mem_ready),
    .out_req    (out_req)
  );

  assign bus.s_axis_ready = s_ready_c;
  assign bus.mem_addr     = out_req.addr;
  assign bus.mem_data     = out_req.data;

  assign loading       = loading_q;
  assign beats_written = beats_written_q;
  assign err_orphan    = err_orphan_q;

endmodule
